// File: rtl/nabp_pkg.sv
// NABP shared definitions: widths mirroring the core's
// constants and the image-RAM writer FSM encoding.
package nabp_pkg;

  localparam int kImageAddressLength = 16;
  localparam int kCacheDataLength    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } nabp_state_e;

endpackage

// File: rtl/nabp_sync_fifo.sv
// Synchronous FIFO with wrap-around pointers; also exposes
// the head, emptiness and free space as they will be after this cycle.
module nabp_sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           head_next,
  output logic                   full,
  output logic                   empty,
  output logic                   empty_next,
  output logic [$clog2(DEPTH):0] free_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic [AW:0]  wr_d;
  logic [AW:0]  rd_d;
  logic         do_push;
  logic         do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // a full FIFO still takes a push when it pops the same cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign wr_d = wr_q + {{AW{1'b0}}, do_push};
  assign rd_d = rd_q + {{AW{1'b0}}, do_pop};

  assign empty_next = (wr_d == rd_d);
  assign free_count = DEPTH_P - (wr_d - rd_d);

  // new head is the incoming word when it lands in an emptied FIFO
  assign head_next = (rd_d == wr_q) ? wdata
                                    : mem[rd_d[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/nabp_image_ram_writer.sv
// NABP image RAM writer: buffers core pixels and commits them
// to the external image RAM over a valid/ready write port.
module nabp_image_ram_writer
  import nabp_pkg::*;
#(
  parameter int ADDR_W     = kImageAddressLength,
  parameter int DATA_W     = kCacheDataLength,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ir_kick,
  input  logic              ir_addr_valid,
  input  logic [ADDR_W-1:0] ir_addr,
  input  logic [DATA_W-1:0] ir_val,
  input  logic              ir_done,
  output logic              ir_enable,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic              mem_ready,
  output logic              hs_done,
  output logic              hs_busy,
  output logic              err_overflow,
  output logic [ADDR_W:0]   pix_count
);

  localparam int PW = ADDR_W + DATA_W;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W:0] PIX_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] PIX_MAX = {1'b1, {ADDR_W{1'b0}}};

  nabp_state_e state_q;
  nabp_state_e state_d;

  logic          push;
  logic          wr_fire;
  logic          frame_start;
  logic          overflow_set;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_empty_next;
  logic [PW-1:0] fifo_head_next;
  logic [CW-1:0] fifo_free;

  assign push         = (state_q == STREAM) && ir_addr_valid;
  assign wr_fire      = mem_we && mem_ready;
  assign frame_start  = (state_q == IDLE) && ir_kick;
  assign overflow_set = push && fifo_full && !wr_fire;

  nabp_sync_fifo #(
    .W     (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .pop        (wr_fire),
    .wdata      ({ir_addr, ir_val}),
    .head_next  (fifo_head_next),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .empty_next (fifo_empty_next),
    .free_count (fifo_free)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (ir_kick) state_d = STREAM;
      STREAM: if (ir_done) state_d = DRAIN;
      DRAIN:  if (fifo_empty && !mem_we) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign hs_done = (state_q == DONE);
  assign hs_busy = (state_q == STREAM) ||
                   (state_q == DRAIN);

  // enable keeps one entry spare for the pixel the core
  // may still present after it sees enable drop
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ir_enable <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
    end else begin
      ir_enable <= (state_d == STREAM) &&
                   (fifo_free >= CW'(2));
      mem_we    <= !fifo_empty_next;
      if (!fifo_empty_next) begin
        {mem_addr, mem_data} <= fifo_head_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pix_count    <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (frame_start) begin
        pix_count <= '0;
      end else if (wr_fire && pix_count != PIX_MAX) begin
        pix_count <= pix_count + PIX_ONE;
      end
      if (frame_start) begin
        err_overflow <= 1'b0;
      end else if (overflow_set) begin
        err_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nabp_image_ram_writer.sv
// Bench for nabp_image_ram_writer: vector table, directed
// corner sequences and random frames against a queue model.
module tb_nabp_image_ram_writer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ir_kick;
  logic        ir_addr_valid;
  logic [15:0] ir_addr;
  logic [15:0] ir_val;
  logic        ir_done;
  logic        ir_enable;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_ready;
  logic        hs_done;
  logic        hs_busy;
  logic        err_overflow;
  logic [16:0] pix_count;

  always #5 clk = ~clk;

  nabp_image_ram_writer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ir_kick       (ir_kick),
    .ir_addr_valid (ir_addr_valid),
    .ir_addr       (ir_addr),
    .ir_val        (ir_val),
    .ir_done       (ir_done),
    .ir_enable     (ir_enable),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .mem_ready     (mem_ready),
    .hs_done       (hs_done),
    .hs_busy       (hs_busy),
    .err_overflow  (err_overflow),
    .pix_count     (pix_count)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } pix_t;

  typedef struct {
    bit          k;
    bit          v;
    logic [15:0] a;
    logic [15:0] d;
    bit          dn;
    bit          rdy;
    bit          e_en;
    bit          e_we;
    logic [15:0] e_addr;
    bit          e_busy;
    bit          e_done;
    int          e_pix;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  // reference model: frame phase, buffered pixels, flags
  int   m_phase;  // 0 idle, 1 streaming, 2 draining, 3 done
  pix_t q[$];
  pix_t m_log[$];
  pix_t d_log[$];
  bit   m_en;
  bit   m_err;
  int   m_pix;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    int  nph;
    bit  fire;
    if (!reset_n) begin
      m_phase = 0;
      q.delete();
      m_en = 0;
      m_err = 0;
      m_pix = 0;
      return;
    end
    fire = (q.size() > 0) && mem_ready;
    nph = m_phase;
    case (m_phase)
      0: if (ir_kick) begin
           nph = 1;
           m_pix = 0;
           m_err = 0;
         end
      1: if (ir_done) nph = 2;
      2: if (q.size() == 0) nph = 3;
      default: nph = 0;
    endcase
    if (fire) begin
      m_log.push_back(q.pop_front());
      if (m_pix < 65536) m_pix++;
    end
    if (m_phase == 1 && ir_addr_valid) begin
      if (q.size() < DEPTH) q.push_back({ir_addr, ir_val});
      else m_err = 1;
    end
    m_en = (nph == 1) && ((DEPTH - q.size()) >= 2);
    m_phase = nph;
  endtask

  task automatic compare();
    chk("mem_we", mem_we, q.size() > 0);
    if (q.size() > 0) begin
      chk("mem_addr", mem_addr, q[0].a);
      chk("mem_data", mem_data, q[0].d);
    end
    chk("ir_enable", ir_enable, m_en);
    chk("hs_busy", hs_busy, m_phase == 1 || m_phase == 2);
    chk("hs_done", hs_done, m_phase == 3);
    chk("err_overflow", err_overflow, m_err);
    chk("pix_count", pix_count, m_pix);
  endtask

  task automatic step(input bit k, input bit v,
                      input logic [15:0] a,
                      input logic [15:0] d,
                      input bit dn, input bit rdy);
    ir_kick = k;
    ir_addr_valid = v;
    ir_addr = a;
    ir_val = d;
    ir_done = dn;
    mem_ready = rdy;
    if (reset_n && mem_we && mem_ready)
      d_log.push_back({mem_addr, mem_data});
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic start_frame();
    m_log.delete();
    d_log.delete();
    step(1, 0, 0, 0, 0, 1);
  endtask

  task automatic end_frame();
    int ndone = 0;
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      step(0, 0, 0, 0, 0, ($urandom % 4) != 0);
      if (hs_done) begin
        ndone++;
        seen = 1;
      end
    end
    if (!seen) chk("hs_done_timeout", 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 1);
      if (hs_done) ndone++;
    end
    chk("hs_done_pulses", ndone, 1);
    chk("write_count", d_log.size(), m_log.size());
    for (int i = 0; i < d_log.size() && i < m_log.size(); i++) begin
      chk("write_addr", d_log[i].a, m_log[i].a);
      chk("write_data", d_log[i].d, m_log[i].d);
    end
  endtask

  task automatic rand_frame(input bit ignore_en);
    int n;
    int sent = 0;
    int guard = 0;
    bit prev_en = 0;
    bit v;
    bit dn_sent = 0;
    start_frame();
    n = $urandom_range(1, 20);
    while (sent < n && guard < 400) begin
      guard++;
      if (ignore_en) v = $urandom % 2;
      else v = (($urandom % 4) != 0) && (ir_enable || prev_en);
      prev_en = ir_enable;
      dn_sent = v && (sent == n - 1);
      step(0, v, 16'($urandom), 16'($urandom), dn_sent,
           ($urandom % 3) != 0);
      if (v) sent++;
    end
    if (!dn_sent) step(0, 0, 0, 0, 1, 1);
    end_frame();
    if (!ignore_en) chk("rand_no_overflow", err_overflow, 0);
  endtask

  vec_t tbl[7];
  int nd;
  bit pe;
  bit vv;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1, 0, 16'h00, 16'h00, 0, 1, 1, 0, 16'h00, 1, 0, 0};
    tbl[1] = '{0, 1, 16'h10, 16'h30, 0, 1, 1, 1, 16'h10, 1, 0, 0};
    tbl[2] = '{0, 1, 16'h11, 16'h33, 0, 1, 1, 1, 16'h11, 1, 0, 1};
    tbl[3] = '{0, 1, 16'h12, 16'h36, 1, 1, 0, 1, 16'h12, 1, 0, 2};
    tbl[4] = '{0, 0, 16'h00, 16'h00, 0, 1, 0, 0, 16'h00, 1, 0, 3};
    tbl[5] = '{0, 0, 16'h00, 16'h00, 0, 1, 0, 0, 16'h00, 0, 1, 3};
    tbl[6] = '{0, 0, 16'h00, 16'h00, 0, 1, 0, 0, 16'h00, 0, 0, 3};

    reset_n = 0;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_enable", ir_enable, 0);
    chk("rst_busy", hs_busy, 0);
    chk("rst_done", hs_done, 0);
    chk("rst_err", err_overflow, 0);
    chk("rst_pix", pix_count, 0);
    reset_n = 1;

    for (int i = 0; i < 7; i++) begin
      step(tbl[i].k, tbl[i].v, tbl[i].a, tbl[i].d,
           tbl[i].dn, tbl[i].rdy);
      chk("tbl_enable", ir_enable, tbl[i].e_en);
      chk("tbl_mem_we", mem_we, tbl[i].e_we);
      if (tbl[i].e_we) chk("tbl_mem_addr", mem_addr, tbl[i].e_addr);
      chk("tbl_busy", hs_busy, tbl[i].e_busy);
      chk("tbl_done", hs_done, tbl[i].e_done);
      chk("tbl_pix", pix_count, tbl[i].e_pix);
    end

    // stream without stall
    start_frame();
    for (int i = 0; i < 16; i++) step(0, 1, 16'(i), 16'(i * 3), 0, 1);
    step(0, 0, 0, 0, 1, 1);
    end_frame();
    chk("t1_count", d_log.size(), 16);
    for (int i = 0; i < d_log.size(); i++) begin
      chk("t1_addr", d_log[i].a, i);
      chk("t1_data", d_log[i].d, i * 3);
    end
    chk("t1_pix", pix_count, 16);
    chk("t1_err", err_overflow, 0);

    // stray pixels in IDLE
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 16'h55, 16'h66, 0, 1);
      chk("idle_mem_we", mem_we, 0);
      chk("idle_pix", pix_count, 16);
      chk("idle_err", err_overflow, 0);
    end

    // back-pressure with the core obeying ir_enable
    start_frame();
    pe = 0;
    for (int i = 0; i < 10; i++) begin
      vv = ir_enable || pe;
      pe = ir_enable;
      step(0, vv, 16'(16'h100 + i), 16'(i), 0, 0);
    end
    chk("bp_err", err_overflow, 0);
    chk("bp_enable", ir_enable, 0);
    chk("bp_head", mem_addr, 16'h100);
    step(0, 0, 0, 0, 1, 1);
    end_frame();
    chk("bp_count", d_log.size(), DEPTH);

    // forced overflow
    start_frame();
    for (int i = 0; i < 6; i++) step(0, 1, 16'(16'h200 + i), 0, 0, 0);
    chk("ovf_set", err_overflow, 1);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("ovf_sticky", err_overflow, 1);
    end_frame();
    chk("ovf_count", d_log.size(), DEPTH);
    if (d_log.size() > 0) chk("ovf_last", d_log[d_log.size()-1].a, 16'h203);
    chk("ovf_after_done", err_overflow, 1);

    // next kick clears the error; a stray kick does not restart
    start_frame();
    chk("kick_clr_err", err_overflow, 0);
    step(0, 1, 16'h300, 16'h1, 0, 1);
    step(1, 1, 16'h301, 16'h2, 0, 1);
    chk("stray_kick_busy", hs_busy, 1);
    step(0, 1, 16'h302, 16'h3, 1, 1);
    end_frame();
    chk("stray_kick_pix", pix_count, 3);

    // ir_done together with the last pixel
    start_frame();
    step(0, 1, 16'd5, 16'h5, 0, 0);
    step(0, 1, 16'd6, 16'h6, 0, 0);
    step(0, 1, 16'd7, 16'h7, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("lastpix_no_done", hs_done, 0);
    end
    end_frame();
    if (d_log.size() > 0) chk("lastpix_addr", d_log[d_log.size()-1].a, 7);

    // reset with three entries buffered
    start_frame();
    for (int i = 0; i < 3; i++) step(0, 1, 16'(16'h400 + i), 0, 0, 0);
    reset_n = 0;
    step(0, 0, 0, 0, 0, 0);
    reset_n = 1;
    chk("mrst_mem_we", mem_we, 0);
    chk("mrst_busy", hs_busy, 0);
    chk("mrst_pix", pix_count, 0);
    nd = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 1);
      if (hs_done) nd++;
    end
    chk("mrst_no_done", nd, 0);
    start_frame();
    for (int i = 0; i < 4; i++) step(0, 1, 16'(16'h500 + i), 0, 0, 1);
    step(0, 0, 0, 0, 1, 1);
    end_frame();
    chk("mrst_frame_pix", pix_count, 4);

    for (int f = 0; f < 24; f++) rand_frame((f % 4) == 3);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
